// File: rtl/cape_pkg.sv
// Shared types, mode encodings and the trailing-zero mask helper for the CAPE
// stochastic number generator.
package cape_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic MODE_UNCORR = 1'b0;
  localparam logic MODE_CORR   = 1'b1;

  // Operands wider than this are not supported by tz_mask; callers truncate.
  localparam int TZ_MAX_W = 64;

  // Bit j of the result is 1 iff bits 0..j of x are all zero.
  function automatic logic [TZ_MAX_W-1:0] tz_mask(input logic [TZ_MAX_W-1:0] x);
    logic                seen;
    logic [TZ_MAX_W-1:0] m;
    seen = 1'b0;
    m    = '0;
    for (int j = 0; j < TZ_MAX_W; j++) begin
      seen = seen | x[j];
      m[j] = ~seen;
    end
    return m;
  endfunction

endpackage

// File: rtl/cape_bp_ctr.sv
// Binary up-counter whose bypassed bits stay at zero while the carry ripples
// straight through them; ovf flags the last live count.
module cape_bp_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] bp,
  output logic [W-1:0] cnt,
  output logic         ovf
);

  logic [W-1:0] cnt_nxt;

  // Forcing bypassed bits to 1 before the add lets the carry skip over them.
  assign cnt_nxt = ((cnt | bp) + W'(1)) & ~bp;
  assign ovf     = &(cnt | bp);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/cape_sng.sv
// Multi-channel CAPE stochastic number generator with correlated/uncorrelated
// modes. Define CAPE_SNG_ET_EN to enable trailing-zero early termination.
module cape_sng
  import cape_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  corr,
  input  logic [WIDTH-1:0]      Bxs [NUM_INPUTS],
  input  logic [WIDTH-1:0]      trunc,
  input  logic                  en,
  output logic                  busy,
  output logic                  valid,
  output logic                  last,
  output logic [NUM_INPUTS-1:0] Xs
);

  localparam int CW = WIDTH * NUM_INPUTS;

  state_t                state, state_nxt;
  logic                  accept, step, ctr_clr, ctr_en;
  logic                  corr_r;
  logic [WIDTH-1:0]      bx_t_r [NUM_INPUTS];
  logic [CW-1:0]         bp, cnt;
  logic                  ovf;
  logic [WIDTH-1:0]      cmp [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] x_p0;
  logic [NUM_INPUTS-1:0] xs_p1;
  logic                  vld_p1, last_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    ctr_clr   = 1'b0;
    ctr_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          ctr_clr   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (en) begin
          step   = 1'b1;
          ctr_en = 1'b1;
          if (ovf) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_RUN);

  // Operands are captured once per stream so later changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (accept) begin
      corr_r <= corr;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        bx_t_r[i] <= Bxs[i] & ~trunc;
      end
    end
  end

`ifdef CAPE_SNG_ET_EN
  logic [WIDTH-1:0] tz [NUM_INPUTS];

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      tz[i] = WIDTH'(tz_mask(TZ_MAX_W'(bx_t_r[i])));
    end
  end
`endif

  always_comb begin
    bp = '0;
    if (corr_r == MODE_CORR) begin
      for (int b = WIDTH; b < CW; b++) begin
        bp[b] = 1'b1;
      end
`ifdef CAPE_SNG_ET_EN
      // A shared bit may be skipped only if it is a trailing zero for all channels.
      for (int j = 0; j < WIDTH; j++) begin
        bp[j] = 1'b1;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          bp[j] = bp[j] & tz[i][j];
        end
      end
`endif
    end
`ifdef CAPE_SNG_ET_EN
    else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        for (int j = 0; j < WIDTH; j++) begin
          bp[j*NUM_INPUTS+i] = tz[i][j];
        end
      end
    end
`endif
  end

  cape_bp_ctr #(
    .W (CW)
  ) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .bp  (bp),
    .cnt (cnt),
    .ovf (ovf)
  );

  // Stage p0: compare each channel's counter view against its operand.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        cmp[i][j] = cnt[j*NUM_INPUTS+i];
      end
      if (corr_r == MODE_CORR) cmp[i] = cnt[WIDTH-1:0];
      x_p0[i] = (cmp[i] < bx_t_r[i]);
    end
  end

  // Stage p1: registered stream bit, valid and end-of-stream flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      xs_p1   <= '0;
    end else begin
      vld_p1  <= step;
      last_p1 <= step & ovf;
      if (step) xs_p1 <= x_p0;
    end
  end

  assign valid = vld_p1;
  assign last  = last_p1;
  assign Xs    = xs_p1;

endmodule
